clk_div_prog: RTL

Programmable integer clock divider for the system clock tree, generalising the fixed even-ratio divider.
- Supports any ratio from 2 to 2^WIDTH-1, odd and even.
- Ratio changes are glitch-free: a new ratio takes effect only at a period boundary, acknowledged by a load/ack handshake.
- Emits a one-cycle tick aligned to each divided-clock rising edge, for use as a synchronous enable by downstream blocks.

---
 rtl/clk_div_prog.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider (ratio 2..2^WIDTH-1) with glitch-free ratio
// reload handshake and rising-edge tick. Define CLK_DIV_ODD50_EN for 50% duty on odd ratios.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_RATIO = 2
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  input  logic             i_ratio_load,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_ratio_ack,
  output logic             o_active
);

  localparam logic [WIDTH-1:0] RESET_RATIO_W = WIDTH'(RESET_RATIO);
  localparam logic [WIDTH-1:0] ONE_W         = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_W         = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_act_q, r_act_d;
  logic [WIDTH-1:0] pend_ratio_q, pend_ratio_d;
  logic             pend_q, pend_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             active_q, active_d;

  logic             run_s;
  logic             boundary_s;
  logic             apply_s;
  logic [WIDTH-1:0] half_s;
  logic [WIDTH-1:0] last_s;
  logic [WIDTH-1:0] cnt_inc_s;

  // Divider counter, phase output and ratio handshake next-state
  always_comb begin
    cnt_d        = cnt_q;
    r_act_d      = r_act_q;
    pend_ratio_d = pend_ratio_q;
    pend_d       = pend_q;
    div_d        = div_q;
    tick_d       = 1'b0;
    ack_d        = 1'b0;
    active_d     = active_q;

    run_s      = i_clk_en && (r_act_q >= TWO_W);
    half_s     = r_act_q >> 1;
    last_s     = r_act_q - ONE_W;
    cnt_inc_s  = cnt_q + ONE_W;
    // A boundary is either the last count of a running period or any idle edge
    boundary_s = !active_q || (cnt_q == last_s);
    apply_s    = pend_q && boundary_s;

    if (run_s) begin
      if (boundary_s) begin
        cnt_d    = '0;
        div_d    = 1'b1;
        tick_d   = 1'b1;
        active_d = 1'b1;
      end else begin
        cnt_d    = cnt_inc_s;
        div_d    = (cnt_inc_s < half_s);
        tick_d   = 1'b0;
        active_d = active_q;
      end
    end else begin
      cnt_d    = '0;
      div_d    = 1'b0;
      tick_d   = 1'b0;
      active_d = 1'b0;
    end

    // Apply consumes the value pending before this edge; a same-edge load re-arms pend
    if (apply_s) begin
      r_act_d = pend_ratio_q;
      ack_d   = 1'b1;
    end else begin
      r_act_d = r_act_q;
      ack_d   = 1'b0;
    end

    if (i_ratio_load) begin
      pend_ratio_d = i_div_ratio;
      pend_d       = 1'b1;
    end else if (apply_s) begin
      pend_ratio_d = pend_ratio_q;
      pend_d       = 1'b0;
    end else begin
      pend_ratio_d = pend_ratio_q;
      pend_d       = pend_q;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q        <= '0;
      r_act_q      <= RESET_RATIO_W;
      pend_ratio_q <= '0;
      pend_q       <= 1'b0;
      div_q        <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      r_act_q      <= r_act_d;
      pend_ratio_q <= pend_ratio_d;
      pend_q       <= pend_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
      active_q     <= active_d;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic div_neg_q;

  // Half-cycle delayed copy stretches the high phase by half a cycle on odd ratios
  always_ff @(negedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      div_neg_q <= 1'b0;
    end else begin
      div_neg_q <= div_q;
    end
  end

  assign o_div_clk = r_act_q[0] ? (div_q | div_neg_q) : div_q;
`else
  assign o_div_clk = div_q;
`endif

  assign o_tick      = tick_q;
  assign o_ratio_ack = ack_q;
  assign o_active    = active_q;

endmodule
